aclint_multi: RTL and testbench
===============================

ACLINT_MULTI -- requirements
Module: aclint_multi

Interface
REQ-001 SHALL have parameter NHARTS, default 1, number of harts served (legal 1..8).
REQ-002 SHALL have parameter XLEN, default 32, data bus width (only 32 supported).
REQ-003 SHALL have parameter ADDR_W, default 16, byte address width.
REQ-004 SHALL have parameter PRESCALE, default 1, i_clk cycles per mtime tick (legal 1..65535).
REQ-005 SHALL have port i_clk, input, 1, sole clock, rising-edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_re, input, 1, read strobe.
REQ-008 SHALL have port i_we, input, 1, write strobe.
REQ-009 SHALL have port i_addr, input, ADDR_W, byte address; bits [1:0] ignored.
REQ-010 SHALL have port i_wdata, input, XLEN, write data.
REQ-011 SHALL have port o_rdata, output, XLEN, registered read data.
REQ-012 SHALL have port o_mtip, output, NHARTS, per-hart machine timer interrupt pending.
REQ-013 SHALL have port o_msip, output, NHARTS, per-hart machine software interrupt pending.

Function
REQ-014 SHALL map msip[h] at 0x0000+4h (bit 0 only, other bits read 0), mtimecmp[h] lo/hi at 0x4000+8h / 0x4004+8h, mtime lo/hi at 0xBFF8 / 0xBFFC.
REQ-015 SHALL treat hart index h >= NHARTS and any other address as unmapped: reads return 0, writes ignored.
REQ-016 SHALL return read data on o_rdata in the cycle after i_re is sampled high; o_rdata holds its value when i_re is low.
REQ-017 SHALL commit writes on the clock edge where i_we is high; i_re and i_we both high to same address returns pre-write data.
REQ-018 SHALL keep a free-running prescaler counting 0..PRESCALE-1 and increment 64-bit mtime by 1 on the cycle the prescaler wraps; mtime wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-019 SHALL give a mtime write priority over the tick in the same cycle: written half takes i_wdata, other half keeps its value (no increment), prescaler resets to 0.
REQ-020 SHALL carry the low-to-high increment so a tick at mtime lo 0xFFFF_FFFF increments mtime hi in the same cycle.
REQ-021 SHALL register o_mtip[h] = (mtime >= mtimecmp[h]) unsigned 64-bit, one cycle after the compared values update.
REQ-022 SHALL drive o_msip[h] directly from msip[h] register (visible the cycle after the write).
REQ-023 SHALL deassert o_mtip[h] one cycle after a mtimecmp write makes mtimecmp[h] > mtime.

Reset
REQ-024 SHALL on i_rst_n low, asynchronously, clear mtime, prescaler, msip, o_mtip, o_msip, o_rdata to 0 and set every mtimecmp to 0xFFFF_FFFF_FFFF_FFFF.
REQ-025 SHALL resume counting from mtime 0 on the first rising edge after i_rst_n deasserts; a read in flight at reset is discarded.

Configuration
REQ-026 SHALL, with ACLINT_MTIME_HALT_EN defined, add input port i_halt (1 bit) which freezes prescaler and mtime while high (writes still accepted, o_mtip still evaluated).
REQ-027 SHALL, without ACLINT_MTIME_HALT_EN, have no i_halt port and count unconditionally.

Verification
REQ-028 SHALL cover: reset, NHARTS=2 -> read 0x4000 = 0xFFFF_FFFF, 0xBFF8 = 0, o_mtip=2'b00, o_msip=2'b00.
REQ-029 SHALL cover: PRESCALE=4, run 40 cycles after reset -> mtime lo reads 10 (+/-1 for read latency, checked exactly against model).
REQ-030 SHALL cover: write mtime lo 0xFFFF_FFFE, hi 0 -> after 2 ticks lo=0, hi=1.
REQ-031 SHALL cover: NHARTS=2, mtimecmp[1]=0x20 (hi 0) -> o_mtip=2'b10 one cycle after mtime reaches 0x20; write mtimecmp[1] lo 0x100 -> o_mtip[1] drops next cycle.
REQ-032 SHALL cover: write 1 to 0x0004 with NHARTS=2 -> o_msip=2'b10; write 1 to 0x0008 -> ignored, read returns 0.
REQ-033 SHALL cover: ACLINT_MTIME_HALT_EN defined, i_halt high 20 cycles -> mtime unchanged; low -> counting resumes.

Source files
------------

// File: rtl/aclint_multi.sv
// rtl/aclint_multi.sv - multi-hart machine timer / software interrupt block
//
// Purpose: one shared 64-bit mtime with a clock prescaler, plus a mtimecmp
// and msip register per hart. Each hart gets a registered timer interrupt
// and a software interrupt.
//
// Parameters: NHARTS (1..8), XLEN (32), ADDR_W (byte address width),
//             PRESCALE (i_clk cycles per mtime tick, 1..65535)
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_halt                  freeze mtime/prescaler (only with ACLINT_MTIME_HALT_EN)
//   i_re, i_we              read / write strobes
//   i_addr, i_wdata         byte address (bits [1:0] ignored), write data
//   o_rdata                 registered read data, held while i_re is low
//   o_mtip, o_msip          per-hart timer / software interrupt pending
// Optional feature macro: ACLINT_MTIME_HALT_EN
//
// Memory map: msip[h] 0x0000+4h, mtimecmp[h] lo/hi 0x4000+8h / 0x4004+8h,
//             mtime lo/hi 0xBFF8 / 0xBFFC; everything else reads 0.

module aclint_multi #(
  parameter int NHARTS   = 1,
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 16,
  parameter int PRESCALE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
`ifdef ACLINT_MTIME_HALT_EN
  input  logic              i_halt,
`endif
  input  logic              i_re,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [XLEN-1:0]   o_rdata,
  output logic [NHARTS-1:0] o_mtip,
  output logic [NHARTS-1:0] o_msip
);

  logic              halt;
`ifdef ACLINT_MTIME_HALT_EN
  assign halt = i_halt;
`else
  assign halt = 1'b0;
`endif

  // Sub-word address bits carry no meaning.
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^i_addr[1:0];

  logic [ADDR_W-1:0] addr_w;
  assign addr_w = {i_addr[ADDR_W-1:2], 2'b00};

  logic [15:0]       presc_q, presc_d;
  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q [NHARTS];
  logic [63:0]       mtimecmp_d [NHARTS];
  logic [NHARTS-1:0] msip_q, msip_d;
  logic [NHARTS-1:0] mtip_q, mtip_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              sel_mtime_lo, sel_mtime_hi;
  logic [NHARTS-1:0] sel_msip, sel_cmp_lo, sel_cmp_hi;
  logic              tick;

  // Address decode; hart slots beyond NHARTS simply never match.
  always_comb begin
    sel_mtime_lo = (addr_w == ADDR_W'(32'hBFF8));
    sel_mtime_hi = (addr_w == ADDR_W'(32'hBFFC));
    sel_msip     = '0;
    sel_cmp_lo   = '0;
    sel_cmp_hi   = '0;
    for (int h = 0; h < NHARTS; h++) begin
      sel_msip[h]   = (addr_w == ADDR_W'(32'h0000 + 4 * h));
      sel_cmp_lo[h] = (addr_w == ADDR_W'(32'h4000 + 8 * h));
      sel_cmp_hi[h] = (addr_w == ADDR_W'(32'h4004 + 8 * h));
    end
  end

  assign tick = (presc_q == 16'(PRESCALE - 1));

  // mtime / prescaler next state. A software write to either half wins over
  // the tick: the other half is left untouched and the prescaler restarts.
  // Writes are honoured even while halted.
  always_comb begin
    presc_d = presc_q;
    mtime_d = mtime_q;
    if (i_we && sel_mtime_lo) begin
      mtime_d[31:0] = i_wdata[31:0];
      presc_d       = '0;
    end else if (i_we && sel_mtime_hi) begin
      mtime_d[63:32] = i_wdata[31:0];
      presc_d        = '0;
    end else if (!halt) begin
      if (tick) begin
        presc_d = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // Per-hart registers and interrupt compare. The compare uses current
  // register values, so o_mtip lags any mtime/mtimecmp change by one cycle.
  always_comb begin
    msip_d = msip_q;
    mtip_d = '0;
    for (int h = 0; h < NHARTS; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      if (i_we && sel_msip[h])   msip_d[h]             = i_wdata[0];
      if (i_we && sel_cmp_lo[h]) mtimecmp_d[h][31:0]  = i_wdata[31:0];
      if (i_we && sel_cmp_hi[h]) mtimecmp_d[h][63:32] = i_wdata[31:0];
      mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  // Read mux works on pre-write state so a same-cycle read/write returns
  // the old value.
  always_comb begin
    rdata_d = '0;
    if (sel_mtime_lo) rdata_d = mtime_q[31:0];
    if (sel_mtime_hi) rdata_d = mtime_q[63:32];
    for (int h = 0; h < NHARTS; h++) begin
      if (sel_msip[h])   rdata_d = XLEN'(msip_q[h]);
      if (sel_cmp_lo[h]) rdata_d = mtimecmp_q[h][31:0];
      if (sel_cmp_hi[h]) rdata_d = mtimecmp_q[h][63:32];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      mtime_q <= '0;
      msip_q  <= '0;
      mtip_q  <= '0;
      rdata_q <= '0;
      for (int h = 0; h < NHARTS; h++) mtimecmp_q[h] <= '1;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      if (i_re) rdata_q <= rdata_d;
      for (int h = 0; h < NHARTS; h++) mtimecmp_q[h] <= mtimecmp_d[h];
    end
  end

  assign o_rdata = rdata_q;
  assign o_mtip  = mtip_q;
  assign o_msip  = msip_q;

endmodule

// File: tb/tb_aclint_multi.sv
// tb/tb_aclint_multi.sv - directed self-checking bench for aclint_multi
//
// Runs NHARTS=2, PRESCALE=4. Inputs change on the falling edge, outputs are
// sampled on the falling edge. After each reset release no rising edge has
// yet occurred; with PRESCALE=4 mtime ticks on rising edges 4, 8, 12, ...
// unless a mtime write restarts the prescaler.
// With ACLINT_MTIME_HALT_EN defined the halt input is also exercised.

module tb_aclint_multi;

  logic        clk;
  logic        rst_n;
  logic        re;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  mtip;
  logic [1:0]  msip;
`ifdef ACLINT_MTIME_HALT_EN
  logic        halt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] d;

  aclint_multi #(
    .NHARTS  (2),
    .XLEN    (32),
    .ADDR_W  (16),
    .PRESCALE(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
`ifdef ACLINT_MTIME_HALT_EN
    .i_halt (halt),
`endif
    .i_re   (re),
    .i_we   (we),
    .i_addr (addr),
    .i_wdata(wdata),
    .o_rdata(rdata),
    .o_mtip (mtip),
    .o_msip (msip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    re = 1'b0;
    we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] data);
    re = 1'b1;
    addr = a;
    @(negedge clk);
    re = 1'b0;
    data = rdata;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] v);
    we = 1'b1;
    addr = a;
    wdata = v;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    re = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
`ifdef ACLINT_MTIME_HALT_EN
    halt = 1'b0;
`endif
    #2;
    check("reset_rdata", 64'(rdata), 64'h0);
    check("reset_mtip", 64'(mtip), 64'h0);
    check("reset_msip", 64'(msip), 64'h0);

    // Reset values
    do_reset();
    rd(16'hBFF8, d); check("rst_mtime_lo", 64'(d), 64'h0);
    rd(16'h4000, d); check("rst_cmp0_lo", 64'(d), 64'hFFFF_FFFF);
    rd(16'h400C, d); check("rst_cmp1_hi", 64'(d), 64'hFFFF_FFFF);
    check("rst_mtip_run", 64'(mtip), 64'h0);

    // Free-running count: 40 edges at PRESCALE=4 -> 10
    do_reset();
    repeat (40) @(negedge clk);
    rd(16'hBFF8, d); check("run40_mtime_lo", 64'(d), 64'd10);
    rd(16'hBFFC, d); check("run40_mtime_hi", 64'(d), 64'd0);

    // Low-to-high carry: lo=FFFF_FFFE written at edge 1, hi=0 at edge 2,
    // ticks at edges 6 and 10
    do_reset();
    wr(16'hBFF8, 32'hFFFF_FFFE);
    wr(16'hBFFC, 32'h0);
    repeat (4) @(negedge clk);
    rd(16'hBFF8, d); check("carry_lo_1tick", 64'(d), 64'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    rd(16'hBFF8, d); check("carry_lo_2tick", 64'(d), 64'h0);
    rd(16'hBFFC, d); check("carry_hi_2tick", 64'(d), 64'h1);

    // 64-bit wrap: all ones -> 0 on the tick at edge 6
    do_reset();
    wr(16'hBFF8, 32'hFFFF_FFFF);
    wr(16'hBFFC, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    rd(16'hBFFC, d); check("wrap_hi", 64'(d), 64'h0);
    rd(16'hBFF8, d); check("wrap_lo", 64'(d), 64'h0);

    // Write beats the tick: at edge 4 the tick is due, the write wins
    do_reset();
    repeat (3) @(negedge clk);
    wr(16'hBFF8, 32'h100);
    rd(16'hBFF8, d); check("wr_prio_lo", 64'(d), 64'h100);
    repeat (2) @(negedge clk);
    rd(16'hBFF8, d); check("wr_prio_presc", 64'(d), 64'h100);
    rd(16'hBFF8, d); check("wr_prio_tick", 64'(d), 64'h101);

    // Timer interrupt for hart 1: cmp = 0x20, mtime hits 0x20 at edge 128
    do_reset();
    wr(16'h400C, 32'h0);
    wr(16'h4008, 32'h20);
    repeat (126) @(negedge clk);
    check("mtip_before", 64'(mtip), 64'h0);
    @(negedge clk);
    check("mtip_set", 64'(mtip), 64'h2);
    wr(16'h4008, 32'h100);
    check("mtip_hold_wr", 64'(mtip), 64'h2);
    @(negedge clk);
    check("mtip_drop", 64'(mtip), 64'h0);

    // Software interrupts and unmapped slots
    do_reset();
    wr(16'h0004, 32'h1);
    check("msip_h1", 64'(msip), 64'h2);
    wr(16'h0008, 32'h1);
    rd(16'h0008, d); check("msip_h2_unmapped", 64'(d), 64'h0);
    check("msip_after_h2", 64'(msip), 64'h2);
    wr(16'h0000, 32'hFFFF_FFFF);
    rd(16'h0000, d); check("msip_bit0_only", 64'(d), 64'h1);
    check("msip_both", 64'(msip), 64'h3);
    wr(16'h4010, 32'h1234);
    rd(16'h4010, d); check("cmp_h2_unmapped", 64'(d), 64'h0);
    rd(16'h1000, d); check("misc_unmapped", 64'(d), 64'h0);

    // Same-cycle read/write returns old data; o_rdata holds while idle
    re = 1'b1;
    we = 1'b1;
    addr = 16'h4000;
    wdata = 32'h55;
    @(negedge clk);
    re = 1'b0;
    we = 1'b0;
    check("rw_same_old", 64'(rdata), 64'hFFFF_FFFF);
    addr = 16'hBFF8;
    @(negedge clk);
    check("rdata_hold", 64'(rdata), 64'hFFFF_FFFF);
    rd(16'h4000, d); check("rw_same_new", 64'(d), 64'h55);

    // Read in flight when reset hits is discarded
    re = 1'b1;
    addr = 16'h4004;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    re = 1'b0;
    check("rd_flight_rst", 64'(rdata), 64'h0);
    rst_n = 1'b1;

`ifdef ACLINT_MTIME_HALT_EN
    // Halted for 21 edges (including the read), then 8 more edges running
    do_reset();
    halt = 1'b1;
    repeat (20) @(negedge clk);
    rd(16'hBFF8, d); check("halt_frozen", 64'(d), 64'h0);
    halt = 1'b0;
    repeat (8) @(negedge clk);
    rd(16'hBFF8, d); check("halt_resume", 64'(d), 64'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
